// File: rtl/hex_message_scroller.sv
// Rotating message sequencer for a row of 2-bit 7-segment character decoders.
// Rotation is either free-running from a prescaler (RUN) or single-stepped (HOLD).
module hex_message_scroller #(
    parameter int                        NUM_DIGITS = 4,
    parameter int                        TICK_DIV   = 50_000_000,
    parameter logic [2*NUM_DIGITS-1:0]   RESET_MSG  = 8'h1B
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic                      run,
    input  logic                      dir,
    input  logic                      step,
    input  logic                      msg_load,
    input  logic [2*NUM_DIGITS-1:0]   msg_in,
    output logic [2*NUM_DIGITS-1:0]   codes,
    output logic                      running,
    output logic                      shift_evt
);

    localparam int            W    = 2 * NUM_DIGITS;
    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

    typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [W-1:0]    codes_q, codes_d;
    logic            evt_q, evt_d;
    logic [W-1:0]    rot_left, rot_right;
    logic            tick, rotate;

    // Left moves each character one display toward HEX(N-1); right toward HEX0.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_rot
        localparam int LS = (gi + NUM_DIGITS - 1) % NUM_DIGITS;
        localparam int RS = (gi + 1) % NUM_DIGITS;
        assign rot_left[2*gi +: 2]  = codes_q[2*LS +: 2];
        assign rot_right[2*gi +: 2] = codes_q[2*RS +: 2];
    end

    always_comb begin
        state_d = run ? RUN : HOLD;
        tick    = (state_q == RUN) && run && (pre_q == TERM);
        pre_d   = '0;
        if ((state_q == RUN) && run && !tick) begin
            pre_d = pre_q + PW'(1);
        end
        rotate  = tick || ((state_q == HOLD) && step);
        codes_d = codes_q;
        evt_d   = 1'b0;
        // A load wins over any rotation in the same cycle and restarts the period.
        if (msg_load) begin
            codes_d = msg_in;
            pre_d   = '0;
        end else if (rotate) begin
            codes_d = dir ? rot_right : rot_left;
            evt_d   = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= HOLD;
            pre_q   <= '0;
            codes_q <= RESET_MSG;
            evt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            codes_q <= codes_d;
            evt_q   <= evt_d;
        end
    end

    assign codes     = codes_q;
    assign running   = (state_q == RUN);
    assign shift_evt = evt_q;

endmodule

// File: tb/tb_hex_message_scroller.sv
// Directed bench for hex_message_scroller: every change of codes is matched against
// a queue of expected (value, shift_evt, cycle) entries pushed by the stimulus.
module tb_hex_message_scroller;

    logic       Clock = 1'b0;
    logic       Resetn, run, dir, step, msg_load;
    logic [7:0] msg_in;
    logic [7:0] codes;
    logic       running, shift_evt;

    hex_message_scroller #(
        .NUM_DIGITS (4),
        .TICK_DIV   (4),
        .RESET_MSG  (8'h1B)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .run       (run),
        .dir       (dir),
        .step      (step),
        .msg_load  (msg_load),
        .msg_in    (msg_in),
        .codes     (codes),
        .running   (running),
        .shift_evt (shift_evt)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] codes;
        logic       evt;
        int         at;
    } exp_t;

    exp_t       sb[$];
    int         n_vec  = 0;
    int         n_err  = 0;
    int         cyc    = 0;
    logic       mon_en = 1'b0;
    logic [7:0] prev_codes;

    // cyc is the number of rising edges seen; stable when sampled on falling edges.
    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (mon_en) begin
            if (codes !== prev_codes) begin
                n_vec++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_change got=%h at cycle %0d (no change expected)", codes, cyc);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    n_vec++;
                    assert (codes === e.codes) else begin
                        n_err++;
                        $error("FAIL codes got=%h expected=%h", codes, e.codes);
                    end
                    n_vec++;
                    assert (shift_evt === e.evt) else begin
                        n_err++;
                        $error("FAIL shift_evt got=%b expected=%b (codes=%h)", shift_evt, e.evt, codes);
                    end
                    n_vec++;
                    assert (cyc == e.at) else begin
                        n_err++;
                        $error("FAIL change_cycle got=%0d expected=%0d (codes=%h)", cyc, e.at, codes);
                    end
                    $display("vector: codes=%h shift_evt=%b cycle=%0d", codes, shift_evt, cyc);
                end
            end else begin
                n_vec++;
                assert (shift_evt === 1'b0) else begin
                    n_err++;
                    $error("FAIL idle_shift_evt got=%b expected=0 at cycle %0d", shift_evt, cyc);
                end
            end
            prev_codes = codes;
        end
    end

    task automatic push(input logic [7:0] c, input logic e, input int at);
        exp_t x;
        x.codes = c;
        x.evt   = e;
        x.at    = at;
        sb.push_back(x);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge Clock);
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
        $display("check %s: got=%h expected=%h", tag, got, exp);
    endtask

    initial begin
        int b;
        Resetn = 1'b0; run = 1'b0; dir = 1'b0; step = 1'b0;
        msg_load = 1'b0; msg_in = 8'h00;

        // 1. reset
        repeat (2) @(negedge Clock);
        check("reset_codes", codes, 8'h1B);
        check("reset_running", {7'd0, running}, 8'h00);
        check("reset_shift_evt", {7'd0, shift_evt}, 8'h00);
        Resetn     = 1'b1;
        prev_codes = codes;
        mon_en     = 1'b1;
        @(negedge Clock);

        // 2. auto-rotate left every 4 cycles; a step pulse in RUN must be ignored
        b   = cyc;
        run = 1'b1;
        push(8'h6C, 1'b1, b + 5);
        push(8'hB1, 1'b1, b + 9);
        push(8'hC6, 1'b1, b + 13);
        push(8'h1B, 1'b1, b + 17);
        @(negedge Clock);
        check("running_in_run", {7'd0, running}, 8'h01);
        wait_to(b + 6);
        step = 1'b1;
        @(negedge Clock);
        step = 1'b0;
        wait_to(b + 17);

        // 3. auto-rotate right
        dir = 1'b1;
        push(8'hC6, 1'b1, b + 21);
        push(8'hB1, 1'b1, b + 25);
        push(8'h6C, 1'b1, b + 29);
        wait_to(b + 29);

        // 4. HOLD: reload 1B, two step pulses 3 cycles apart, idle, then step held 2 cycles
        run = 1'b0;
        dir = 1'b0;
        @(negedge Clock);
        check("running_in_hold", {7'd0, running}, 8'h00);
        b        = cyc;
        msg_load = 1'b1;
        msg_in   = 8'h1B;
        push(8'h1B, 1'b0, b + 1);
        @(negedge Clock);
        msg_load = 1'b0;
        step     = 1'b1;
        push(8'h6C, 1'b1, b + 2);
        @(negedge Clock);
        step = 1'b0;
        wait_to(b + 4);
        step = 1'b1;
        push(8'hB1, 1'b1, b + 5);
        @(negedge Clock);
        step = 1'b0;
        wait_to(b + 25);
        check("hold_idle_codes", codes, 8'hB1);
        step = 1'b1;
        push(8'hC6, 1'b1, b + 26);
        push(8'h1B, 1'b1, b + 27);
        repeat (2) @(negedge Clock);
        step = 1'b0;
        @(negedge Clock);

        // 5. load in the terminal-count cycle drops the rotation and restarts the period
        b   = cyc;
        run = 1'b1;
        wait_to(b + 4);
        check("pre_load_codes", codes, 8'h1B);
        msg_load = 1'b1;
        msg_in   = 8'hE4;
        push(8'hE4, 1'b0, b + 5);
        push(8'h93, 1'b1, b + 9);
        @(negedge Clock);
        msg_load = 1'b0;
        wait_to(b + 9);

        // 6a. reset at prescaler=2 overrides a same-cycle load
        wait_to(b + 11);
        Resetn   = 1'b0;
        run      = 1'b0;
        msg_load = 1'b1;
        msg_in   = 8'h27;
        push(8'h1B, 1'b0, b + 12);
        @(negedge Clock);
        check("midrun_reset_codes", codes, 8'h1B);
        check("midrun_reset_running", {7'd0, running}, 8'h00);
        Resetn   = 1'b1;
        msg_load = 1'b0;
        @(negedge Clock);

        // 6b. run dropped at prescaler=3: no rotation, then a full period on restart
        b   = cyc;
        run = 1'b1;
        wait_to(b + 4);
        run = 1'b0;
        repeat (8) @(negedge Clock);
        check("run_drop_codes", codes, 8'h1B);
        b   = cyc;
        run = 1'b1;
        push(8'h6C, 1'b1, b + 5);
        wait_to(b + 7);

        n_vec++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL missing_changes got=%0d pending expected=0", sb.size());
        end
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
